// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the byte-stream instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        HDR_LO = 3'd0,
        HDR_HI = 3'd1,
        LOAD   = 3'd2,
        RUN    = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_e;

    localparam int unsigned HDR_BYTES      = 2;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LANE_W         = 2;
    localparam int unsigned CNT_W          = 17;

endpackage

// File: rtl/imem_loader_byte_word_assembler.sv
// Packs little-endian bytes into 32-bit words; word_valid fires with the 4th byte.
module byte_word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_accept,
    input  logic        i_clear,
    input  logic [7:0]  i_byte,
    output logic        o_word_valid_c,
    output logic [31:0] o_word_c
);

    logic [LANE_W-1:0] r_lane;
    logic [31:0]       r_shift;

    // Bytes enter at the top so the first byte ends up in bits 7:0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lane  <= '0;
            r_shift <= '0;
        end else if (i_clear) begin
            r_lane  <= '0;
            r_shift <= '0;
        end else if (i_accept) begin
            r_lane  <= r_lane + LANE_W'(1);
            r_shift <= {i_byte, r_shift[31:8]};
        end
    end

    assign o_word_valid_c = i_accept && (r_lane == LANE_W'(BYTES_PER_WORD - 1));
    assign o_word_c       = {i_byte, r_shift[31:8]};

endmodule

// File: rtl/imem_loader.sv
// Loads a framed program image into instruction memory, then runs the core for N+RUN_EXTRA cycles.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned RUN_EXTRA = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset_n,
    output logic              running,
    output logic              done,
    output logic              err,
    output logic [15:0]       word_count
);

    localparam int unsigned CAPACITY = 1 << ADDR_W;

    state_e            r_state;
    state_e            w_state_next;
    logic              w_accept;
    logic              w_asm_accept;
    logic              w_clear;
    logic              w_word_valid;
    logic              w_last_word;
    logic [31:0]       w_word;
    logic [15:0]       w_hdr_n;
    logic [7:0]        r_hdr_lo;
    logic [CNT_W-1:0]  r_index;
    logic [CNT_W-1:0]  r_run_cnt;

    logic              r_imem_we;
    logic [ADDR_W-1:0] r_imem_addr;
    logic [31:0]       r_imem_wdata;
    logic              r_core_reset_n;
    logic              r_running;
    logic              r_done;
    logic              r_err;
    logic [15:0]       r_word_count;

    assign in_ready     = (r_state != RUN) && (r_state != ERR);
    assign w_accept     = in_valid && in_ready;
    assign w_hdr_n      = {in_data, r_hdr_lo};
    assign w_asm_accept = w_accept && (r_state == LOAD);
    assign w_clear      = w_accept && (r_state == HDR_HI);
    assign w_last_word  = w_word_valid &&
                          ((r_index + CNT_W'(1)) == CNT_W'(r_word_count));

    byte_word_assembler u_asm (
        .clk            (clk),
        .rst            (reset),
        .i_accept       (w_asm_accept),
        .i_clear        (w_clear),
        .i_byte         (in_data),
        .o_word_valid_c (w_word_valid),
        .o_word_c       (w_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= HDR_LO;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            HDR_LO: if (w_accept) w_state_next = HDR_HI;
            HDR_HI: begin
                if (w_accept) begin
                    if (w_hdr_n == 16'd0)              w_state_next = DONE;
                    else if (32'(w_hdr_n) > CAPACITY)  w_state_next = ERR;
                    else                               w_state_next = LOAD;
                end
            end
            LOAD:   if (w_last_word) w_state_next = RUN;
            RUN:    if (r_run_cnt == '0) w_state_next = DONE;
            DONE:   if (w_accept) w_state_next = HDR_HI;
            ERR:    w_state_next = ERR;
            default: w_state_next = HDR_LO;
        endcase
    end

    // Core release is gated on staying in RUN so it rises a cycle after the final write
    // and falls on the same edge that raises done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hdr_lo       <= '0;
            r_index        <= '0;
            r_run_cnt      <= '0;
            r_imem_we      <= 1'b0;
            r_imem_addr    <= '0;
            r_imem_wdata   <= '0;
            r_core_reset_n <= 1'b0;
            r_running      <= 1'b0;
            r_done         <= 1'b0;
            r_err          <= 1'b0;
            r_word_count   <= '0;
        end else begin
            r_imem_we      <= w_word_valid;
            r_core_reset_n <= (r_state == RUN) && (w_state_next == RUN);
            r_running      <= (r_state == RUN) && (w_state_next == RUN);
            r_done         <= (w_state_next == DONE);
            r_err          <= (w_state_next == ERR);

            if (w_accept && ((r_state == HDR_LO) || (r_state == DONE)))
                r_hdr_lo <= in_data;

            if (w_clear) begin
                r_word_count <= w_hdr_n;
                r_index      <= '0;
            end else if (w_word_valid) begin
                r_imem_addr  <= ADDR_W'(r_index);
                r_imem_wdata <= w_word;
                r_index      <= r_index + CNT_W'(1);
            end

            if (w_last_word)
                r_run_cnt <= CNT_W'(r_word_count) + CNT_W'(RUN_EXTRA);
            else if ((r_state == RUN) && (r_run_cnt != '0))
                r_run_cnt <= r_run_cnt - CNT_W'(1);
        end
    end

    assign imem_we      = r_imem_we;
    assign imem_addr    = r_imem_addr;
    assign imem_wdata   = r_imem_wdata;
    assign core_reset_n = r_core_reset_n;
    assign running      = r_running;
    assign done         = r_done;
    assign err          = r_err;
    assign word_count   = r_word_count;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: directed frames, expected writes/run lengths queued, monitor compares.
module tb_imem_loader;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_reset_n;
    logic        running;
    logic        done;
    logic        err;
    logic [15:0] word_count;

    logic        s_in_valid;
    logic [7:0]  s_in_data;
    logic        s_in_ready;
    logic        s_imem_we;
    logic [1:0]  s_imem_addr;
    logic [31:0] s_imem_wdata;
    logic        s_core_reset_n;
    logic        s_running;
    logic        s_done;
    logic        s_err;
    logic [15:0] s_word_count;

    int  n_vec = 0;
    int  n_err = 0;
    int  run_len = 0;
    logic prev_crn = 1'b0;
    wr_t exp_wr[$];
    int  exp_run[$];

    imem_loader #(.ADDR_W(10), .RUN_EXTRA(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .core_reset_n(core_reset_n), .running(running),
        .done(done), .err(err), .word_count(word_count)
    );

    imem_loader #(.ADDR_W(2), .RUN_EXTRA(1)) dut_s (
        .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_data(s_in_data),
        .in_ready(s_in_ready), .imem_we(s_imem_we), .imem_addr(s_imem_addr),
        .imem_wdata(s_imem_wdata), .core_reset_n(s_core_reset_n), .running(s_running),
        .done(s_done), .err(s_err), .word_count(s_word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic exp_write(input logic [9:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_wr.push_back(e);
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        check("in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gappy);
        for (int i = 0; i < 4; i++)
            send(w[8*i +: 8], gappy ? ((i * 3 + 1) % 4) : 0);
    endtask

    task automatic s_send(input logic [7:0] b);
        s_in_valid = 1'b1;
        s_in_data  = b;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check("done_reached", 32'(done), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_core_reset_n", 32'(core_reset_n), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Monitor: writes against the queue, release windows against expected run lengths.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            check("write_while_core_running", 32'(core_reset_n), 32'd0);
            if (exp_wr.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: addr %0d data %h", imem_addr, imem_wdata);
            end else begin
                wr_t e;
                e = exp_wr.pop_front();
                check("write_addr", 32'(imem_addr), 32'(e.addr));
                check("write_data", imem_wdata, e.data);
            end
        end
        if (core_reset_n === 1'b1 || running === 1'b1)
            check("running_vs_core_reset_n", 32'(running), 32'(core_reset_n));
        if (core_reset_n === 1'b1 && !prev_crn) begin
            run_len = 0;
            if (exp_run.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_release: core_reset_n rose with no frame pending");
            end
        end
        if (core_reset_n === 1'b1) run_len++;
        if (core_reset_n === 1'b0 && prev_crn) begin
            if (exp_run.size() != 0) check("run_cycles", 32'(run_len), 32'(exp_run.pop_front()));
            check("done_with_fall", 32'(done), 32'd1);
        end
        prev_crn = (core_reset_n === 1'b1);
        if (s_imem_we === 1'b1 || s_core_reset_n === 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL small_dut_activity: we %b core_reset_n %b", s_imem_we, s_core_reset_n);
        end
    end

    initial begin
        reset      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        s_in_valid = 1'b0;
        s_in_data  = 8'h00;
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_imem_we", 32'(imem_we), 32'd0);
        check("reset_imem_addr", 32'(imem_addr), 32'd0);
        check("reset_imem_wdata", imem_wdata, 32'd0);
        check("reset_core_reset_n", 32'(core_reset_n), 32'd0);
        check("reset_running", 32'(running), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_word_count", 32'(word_count), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Two-word program, gapless.
        exp_write(10'd0, 32'h00A00513);
        exp_write(10'd1, 32'h00B00593);
        exp_run.push_back(3);
        send(8'h02, 0); send(8'h00, 0);
        send(8'h13, 0); send(8'h05, 0); send(8'hA0, 0); send(8'h00, 0);
        send(8'h93, 0); send(8'h05, 0); send(8'hB0, 0); send(8'h00, 0);
        wait_done(50);
        check("t1_word_count", 32'(word_count), 32'd2);
        check("t1_core_held", 32'(core_reset_n), 32'd0);

        // Empty frame from DONE: done clears on first byte, returns with no run.
        send(8'h00, 0);
        check("t2_done_clear", 32'(done), 32'd0);
        send(8'h00, 0);
        check("t2_done", 32'(done), 32'd1);
        check("t2_word_count", 32'(word_count), 32'd0);
        check("t2_core_held", 32'(core_reset_n), 32'd0);
        repeat (3) @(posedge clk);
        #1;

        // Three words with 0..3 cycle gaps between bytes.
        exp_write(10'd0, 32'h11223344);
        exp_write(10'd1, 32'hDEADBEEF);
        exp_write(10'd2, 32'h00000013);
        exp_run.push_back(4);
        send(8'h03, 2);
        check("t3_done_clear", 32'(done), 32'd0);
        send(8'h00, 1);
        send_word(32'h11223344, 1'b1);
        send_word(32'hDEADBEEF, 1'b1);
        send_word(32'h00000013, 1'b1);
        wait_done(50);
        check("t3_word_count", 32'(word_count), 32'd3);

        // One-word frame straight from DONE.
        exp_write(10'd0, 32'hCAFEF00D);
        exp_run.push_back(2);
        send(8'h01, 0);
        check("t4_done_clear", 32'(done), 32'd0);
        send(8'h00, 0);
        send_word(32'hCAFEF00D, 1'b0);
        wait_done(50);
        check("t4_word_count", 32'(word_count), 32'd1);

        // Reset after 6 of 8 payload bytes, then a fresh 1-word frame.
        exp_write(10'd0, 32'h04030201);
        send(8'h02, 0); send(8'h00, 0);
        send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
        send(8'h05, 0); send(8'h06, 0);
        do_reset();
        check("t5_word_count_reset", 32'(word_count), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("t5_no_release", 32'(core_reset_n), 32'd0);
        exp_write(10'd0, 32'h0000006F);
        exp_run.push_back(2);
        send(8'h01, 0); send(8'h00, 0);
        send_word(32'h0000006F, 1'b0);
        wait_done(50);

        // Capacity boundary on a 4-word memory: N=4 loads, N=5 errors until reset.
        s_send(8'h04); s_send(8'h00);
        check("s_n4_err", 32'(s_err), 32'd0);
        check("s_n4_ready", 32'(s_in_ready), 32'd1);
        check("s_n4_word_count", 32'(s_word_count), 32'd4);
        do_reset();
        s_send(8'h05); s_send(8'h00);
        check("s_n5_err", 32'(s_err), 32'd1);
        check("s_n5_ready", 32'(s_in_ready), 32'd0);
        check("s_n5_word_count", 32'(s_word_count), 32'd5);
        repeat (5) @(posedge clk);
        #1;
        s_send(8'h13);
        check("s_err_held", 32'(s_err), 32'd1);
        check("s_core_held", 32'(s_core_reset_n), 32'd0);
        do_reset();
        check("s_err_cleared", 32'(s_err), 32'd0);
        check("s_ready_after_reset", 32'(s_in_ready), 32'd1);

        repeat (3) @(posedge clk);
        #1;
        check("pending_writes", 32'(exp_wr.size()), 32'd0);
        check("pending_runs", 32'(exp_run.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
